puf_fu_ctrl: RTL
================

// Module: puf_fu_ctrl
// PURPOSE
// Execute-stage controller for the PUF functional unit, driven by the issue stage's puf_valid_o.
// Accepts one PUF instruction at a time and sequences the req/gnt/rvalid handshake to the PUF core.
// Returns one result per instruction on a writeback port as {trans_id, data, exception}; the port has no backpressure.
// On flush it drains any in-flight core transaction. Guards against a hung core with a timeout.
// PARAMETERS
// TRANS_ID_BITS  3     scoreboard transaction-id width
// XLEN           64    operand/result width
// TIMEOUT_CYC    1024  WAIT/DRAIN cycles before abort (>=2)
// PORTS
// clk_i              in   1              clock
// rst_ni             in   1              async reset, active low
// flush_i            in   1              kill accepted, unfinished instruction
// puf_valid_i        in   1              issue: instruction valid
// puf_ready_o        out  1              controller idle, can accept
// trans_id_i         in   TRANS_ID_BITS  issue: transaction id
// op_i               in   2              00 RESP, 01 ENROLL, 10 STATUS, 11 illegal
// operand_a_i        in   XLEN           challenge
// puf_req_o          out  1              core request, held until gnt
// puf_mode_o         out  1              0 = response, 1 = enroll
// puf_challenge_o    out  XLEN           core challenge, stable while req
// puf_gnt_i          in   1              core accepted request
// puf_rvalid_i       in   1              core result valid, 1-cycle pulse
// puf_rdata_i        in   XLEN           core result
// wb_valid_o         out  1              writeback pulse
// wb_trans_id_o      out  TRANS_ID_BITS  writeback id
// wb_data_o          out  XLEN           writeback data
// wb_ex_valid_o      out  1              exception flag
// wb_ex_cause_o      out  6              2 = illegal, 5 = access fault (timeout)
// wb_ex_tval_o       out  XLEN           challenge of faulting op, else 0
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except puf_ready_o=1; status counter 0; timeout counter 0.
// - States: IDLE, REQ, WAIT, WB, DRAIN_REQ, DRAIN. puf_ready_o = (state==IDLE).
// - Accept = puf_valid_i & puf_ready_o & ~flush_i; latch trans_id, op and challenge.
// - IDLE, on accept:
//   - op 00/01 -> REQ.
//   - op 10 -> WB; data = {XLEN-16 zeros, status_cnt}.
//   - op 11 -> WB; ex=1, cause=2, tval=0.
// - REQ: puf_req_o=1; mode and challenge from latch. gnt -> WAIT, timeout counter cleared.
//   - flush -> DRAIN_REQ.
// - WAIT: count cycles.
//   - rvalid -> WB; data=rdata; status_cnt+1 (16b, wraps at 0xFFFF -> 0).
//   - Count reaches TIMEOUT_CYC-1 without rvalid -> WB; ex=1, cause=5, tval=challenge, data=0; set stale flag.
//   - flush -> DRAIN.
//   - flush together with rvalid -> IDLE; result discarded, counter unchanged.
// - WB: exactly one cycle; wb_valid_o = ~flush_i; wb_* registered. Next state: DRAIN if stale, else IDLE.
// - DRAIN_REQ: keep puf_req_o=1 until gnt, then DRAIN (req/gnt handshake is never withdrawn).
// - DRAIN: rvalid or timeout -> IDLE; no writeback; stale cleared.
// - Latency: accept at N -> puf_req_o at N+1; gnt at N+1 -> WAIT at N+2; rvalid at M -> wb_valid_o at M+1.
//   Ready again at M+2. STATUS/illegal: wb at N+1.
// - rvalid/gnt outside WAIT/REQ/DRAIN*: ignored.
// - flush in IDLE: no effect. Accept blocked while flush_i=1.
// - Reset mid-operation: immediate return to IDLE. The core is reset by the same rst_ni.
// TESTING
// - RESP op 00, chal=0xA5, id=3; gnt after 1 cycle, rvalid 4 cycles later with 0x1234.
//   -> one wb pulse: id=3, data=0x1234, ex=0; status_cnt=1.
// - STATUS after 2 RESPs -> wb 1 cycle after accept with data=2. Op 11 -> ex=1, cause=2.
// - Core never returns rvalid -> wb ex=1, cause=5, tval=chal exactly TIMEOUT_CYC cycles after gnt.
//   A late rvalid is swallowed in DRAIN; the next op works normally.
// - flush in WAIT, rvalid 3 cycles later -> no wb pulse, ready only after rvalid, status_cnt unchanged.
// - flush in REQ with gnt delayed 5 cycles -> req held until gnt, DRAIN, no wb, then IDLE.
// - Back-to-back RESPs with status_cnt preset to 0xFFFF -> wraps to 0; ready_o low from accept until cycle after WB.

Source files
------------

// File: rtl/puf_fu_ctrl.sv
// Execute-stage controller for the PUF functional unit. It runs one instruction at a time
// through the req/gnt/rvalid core handshake, then drives a single-cycle writeback with flush drain and timeout.
module puf_fu_ctrl #(
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TIMEOUT_CYC   = 1024,
  // Reset value of the status counter; nonzero only to exercise the wrap path at bring-up.
  parameter logic [15:0] STATUS_RST    = 16'h0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     puf_valid_i,
  output logic                     puf_ready_o,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [1:0]               op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  output logic                     puf_req_o,
  output logic                     puf_mode_o,
  output logic [XLEN-1:0]          puf_challenge_o,
  input  logic                     puf_gnt_i,
  input  logic                     puf_rvalid_i,
  input  logic [XLEN-1:0]          puf_rdata_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_data_o,
  output logic                     wb_ex_valid_o,
  output logic [5:0]               wb_ex_cause_o,
  output logic [XLEN-1:0]          wb_ex_tval_o
);

  localparam int unsigned       TCNT_W    = $clog2(TIMEOUT_CYC);
  // The decision is taken on the cycle the count would reach TIMEOUT_CYC-1.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_DRAIN_REQ,
    S_DRAIN
  } state_t;

  state_t                   state;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic                     mode_q;
  logic [XLEN-1:0]          chal_q;
  logic [15:0]              status_cnt;
  logic [TCNT_W-1:0]        tcnt;
  logic                     stale;
  logic                     accept;
  logic                     tmo;

  assign accept          = puf_valid_i & puf_ready_o & ~flush_i;
  assign tmo             = (tcnt == TCNT_LAST);
  assign puf_mode_o      = mode_q;
  assign puf_challenge_o = chal_q;
  assign wb_valid_o      = (state == S_WB) & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      puf_ready_o   <= 1'b1;
      puf_req_o     <= 1'b0;
      id_q          <= '0;
      mode_q        <= 1'b0;
      chal_q        <= '0;
      status_cnt    <= STATUS_RST;
      tcnt          <= '0;
      stale         <= 1'b0;
      wb_trans_id_o <= '0;
      wb_data_o     <= '0;
      wb_ex_valid_o <= 1'b0;
      wb_ex_cause_o <= '0;
      wb_ex_tval_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            id_q        <= trans_id_i;
            mode_q      <= op_i[0];
            chal_q      <= operand_a_i;
            puf_ready_o <= 1'b0;
            case (op_i)
              2'b00, 2'b01: begin
                state     <= S_REQ;
                puf_req_o <= 1'b1;
              end
              2'b10: begin
                state         <= S_WB;
                wb_trans_id_o <= trans_id_i;
                wb_data_o     <= {{(XLEN-16){1'b0}}, status_cnt};
                wb_ex_valid_o <= 1'b0;
                wb_ex_cause_o <= 6'd0;
                wb_ex_tval_o  <= '0;
              end
              default: begin
                state         <= S_WB;
                wb_trans_id_o <= trans_id_i;
                wb_data_o     <= '0;
                wb_ex_valid_o <= 1'b1;
                wb_ex_cause_o <= 6'd2;
                wb_ex_tval_o  <= '0;
              end
            endcase
          end
        end
        S_REQ: begin
          // A granted request has a result on its way, so a flush here must still drain it.
          if (puf_gnt_i) begin
            puf_req_o <= 1'b0;
            tcnt      <= '0;
            state     <= flush_i ? S_DRAIN : S_WAIT;
          end else if (flush_i) begin
            state <= S_DRAIN_REQ;
          end
        end
        S_WAIT: begin
          if (puf_rvalid_i) begin
            if (flush_i) begin
              state       <= S_IDLE;
              puf_ready_o <= 1'b1;
            end else begin
              state         <= S_WB;
              wb_trans_id_o <= id_q;
              wb_data_o     <= puf_rdata_i;
              wb_ex_valid_o <= 1'b0;
              wb_ex_cause_o <= 6'd0;
              wb_ex_tval_o  <= '0;
              status_cnt    <= status_cnt + 16'd1;
            end
          end else if (flush_i) begin
            state <= S_DRAIN;
            tcnt  <= '0;
          end else if (tmo) begin
            state         <= S_WB;
            stale         <= 1'b1;
            wb_trans_id_o <= id_q;
            wb_data_o     <= '0;
            wb_ex_valid_o <= 1'b1;
            wb_ex_cause_o <= 6'd5;
            wb_ex_tval_o  <= chal_q;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        S_WB: begin
          if (stale) begin
            state <= S_DRAIN;
            tcnt  <= '0;
          end else begin
            state       <= S_IDLE;
            puf_ready_o <= 1'b1;
          end
        end
        S_DRAIN_REQ: begin
          if (puf_gnt_i) begin
            puf_req_o <= 1'b0;
            tcnt      <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (puf_rvalid_i || tmo) begin
            state       <= S_IDLE;
            puf_ready_o <= 1'b1;
            stale       <= 1'b0;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: begin
          state       <= S_IDLE;
          puf_ready_o <= 1'b1;
          puf_req_o   <= 1'b0;
          stale       <= 1'b0;
        end
      endcase
    end
  end

endmodule
